// File: rtl/instr_fetch_queue_pkg.sv
// Shared definitions for the instruction fetch queue: default widths,
// reset fetch address and the buffered fetch entry layout.
package instr_fetch_queue_pkg;

    localparam int          FQ_XLEN     = 32;
    localparam int          FQ_DEPTH    = 4;
    localparam logic [31:0] FQ_RESET_PC = 32'h0000_0000;

    // One buffered fetch: the word returned by memory and the PC it was read from.
    typedef struct packed {
        logic [FQ_XLEN-1:0] pc;
        logic [FQ_XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_queue_if.sv
// Handshake bundle between the fetch queue, instruction memory, the execute
// redirect path and decode. master = fetch queue, slave = its environment.
interface instr_fetch_queue_if
    import instr_fetch_queue_pkg::*;
#(
    parameter int XLEN = FQ_XLEN
);
    logic            imem_req_valid;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_req_ready;
    logic            imem_resp_valid;
    logic [XLEN-1:0] imem_resp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            if_valid;
    logic [XLEN-1:0] if_instr;
    logic [XLEN-1:0] if_pc;
    logic            if_ready;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid, imem_resp_data,
        input  redirect_valid, redirect_pc,
        output if_valid, if_instr, if_pc,
        input  if_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid, imem_resp_data,
        output redirect_valid, redirect_pc,
        input  if_valid, if_instr, if_pc,
        output if_ready
    );
endinterface

// File: rtl/instr_fetch_queue_chk.sv
// Simulation-only invariants for the fetch queue: credit accounting and
// response legality.
module instr_fetch_queue_chk #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
)(
    input logic          clk,
    input logic          reset,
    input logic          resp_valid,
    input logic          push,
    input logic          pop,
    input logic          full,
    input logic [CW-1:0] count,
    input logic [CW-1:0] outstanding
);
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    a_credit_bound: assert property (@(posedge clk) disable iff (reset)
        (({1'b0, count} + {1'b0, outstanding}) <= DEPTH_C));

    a_resp_expected: assert property (@(posedge clk) disable iff (reset)
        resp_valid |-> (outstanding != {CW{1'b0}}));

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        (push && full) |-> pop);

endmodule

// File: rtl/instr_fetch_queue_fifo.sv
// Synchronous FIFO holding returned fetch words. Storage is reset to zero so
// the head reads as zero out of reset. Clear empties it in one cycle.
module instr_fetch_queue_fifo
    import instr_fetch_queue_pkg::*;
#(
    parameter int  DEPTH = FQ_DEPTH,
    parameter type T     = fetch_entry_t
)(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       clear,
    input  T                           push_data,
    output T                           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int             AW      = $clog2(DEPTH);
    localparam int             CW      = $clog2(DEPTH+1);
    localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0]  ONE_C   = CW'(1'b1);
    localparam logic [AW-1:0]  PTR_ONE = AW'(1'b1);

    T              mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          do_push_s;
    logic          do_pop_s;

    // Qualify pop against empty and push against full (push into a full FIFO only alongside a pop).
    always_comb begin
        do_pop_s  = pop && (count_r != {CW{1'b0}});
        do_push_s = push && ((count_r != DEPTH_C) || do_pop_s);
    end

    // Pointer, occupancy and storage update; clear takes priority over push/pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (clear) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + ONE_C;
                2'b01:   count_r <= count_r - ONE_C;
                default: count_r <= count_r;
            endcase
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;
    assign full  = (count_r == DEPTH_C);
    assign empty = (count_r == {CW{1'b0}});

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage: owns the fetch PC, issues in-order instruction reads under a
// credit limit of DEPTH (buffered + in flight), tags returned words with their
// PC and presents them to decode. A redirect flushes the buffer and marks every
// still-outstanding read to be dropped on return.
module instr_fetch_queue
    import instr_fetch_queue_pkg::*;
#(
    parameter int              XLEN     = FQ_XLEN,
    parameter int              DEPTH    = FQ_DEPTH,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(FQ_RESET_PC)
)(
    input logic                 clk,
    input logic                 reset,
    instr_fetch_queue_if.master bus
);
    localparam int              CW      = $clog2(DEPTH+1);
    localparam logic [CW:0]     DEPTH_C = (CW+1)'(DEPTH);
    localparam logic [CW-1:0]   ONE_C   = CW'(1'b1);
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(32'd4);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } entry_t;

    logic [XLEN-1:0] fetch_pc_r;
    logic [XLEN-1:0] resp_pc_r;
    logic [CW-1:0]   outstanding_r;
    logic [CW-1:0]   drop_cnt_r;
    logic            run_r;

    logic [CW-1:0]   outstanding_nxt_s;
    logic [CW-1:0]   drop_cnt_nxt_s;
    logic [CW-1:0]   fifo_count_s;
    logic            fifo_empty_s;
    logic            fifo_full_s;
    logic            req_valid_s;
    logic            req_fire_s;
    logic            resp_fire_s;
    logic            push_s;
    logic            pop_s;
    logic            if_valid_s;
    entry_t          push_data_s;
    entry_t          head_s;
    logic [XLEN-1:0] redirect_pc_al_s;
    logic [1:0]      unused_redirect_lsb_s;

    assign redirect_pc_al_s      = {bus.redirect_pc[XLEN-1:2], 2'b00};
    assign unused_redirect_lsb_s = bus.redirect_pc[1:0];

    // Handshake qualification; a response with nothing outstanding is ignored.
    always_comb begin
        req_valid_s = run_r && !bus.redirect_valid &&
                      (({1'b0, fifo_count_s} + {1'b0, outstanding_r}) < DEPTH_C);
        req_fire_s  = req_valid_s && bus.imem_req_ready;
        resp_fire_s = bus.imem_resp_valid && (outstanding_r != {CW{1'b0}});
        push_s      = resp_fire_s && !bus.redirect_valid && (drop_cnt_r == {CW{1'b0}});
        if_valid_s  = !fifo_empty_s && !bus.redirect_valid;
        pop_s       = if_valid_s && bus.if_ready;
        push_data_s = '{pc: resp_pc_r, instr: bus.imem_resp_data};
    end

    // In-flight and drop accounting; a redirect turns everything still in flight into drops.
    always_comb begin
        outstanding_nxt_s = outstanding_r;
        drop_cnt_nxt_s    = drop_cnt_r;
        case ({req_fire_s, resp_fire_s})
            2'b10:   outstanding_nxt_s = outstanding_r + ONE_C;
            2'b01:   outstanding_nxt_s = outstanding_r - ONE_C;
            default: outstanding_nxt_s = outstanding_r;
        endcase
        if (bus.redirect_valid) begin
            drop_cnt_nxt_s = outstanding_nxt_s;
        end else if (resp_fire_s && (drop_cnt_r != {CW{1'b0}})) begin
            drop_cnt_nxt_s = drop_cnt_r - ONE_C;
        end else begin
            drop_cnt_nxt_s = drop_cnt_r;
        end
    end

    // Fetch/response PC tracking, counters, and the post-reset request enable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_r         <= 1'b0;
            fetch_pc_r    <= RESET_PC;
            resp_pc_r     <= RESET_PC;
            outstanding_r <= {CW{1'b0}};
            drop_cnt_r    <= {CW{1'b0}};
        end else begin
            run_r         <= 1'b1;
            outstanding_r <= outstanding_nxt_s;
            drop_cnt_r    <= drop_cnt_nxt_s;
            if (bus.redirect_valid) begin
                fetch_pc_r <= redirect_pc_al_s;
                resp_pc_r  <= redirect_pc_al_s;
            end else begin
                if (req_fire_s) begin
                    fetch_pc_r <= fetch_pc_r + PC_STEP;
                end
                if (push_s) begin
                    resp_pc_r <= resp_pc_r + PC_STEP;
                end
            end
        end
    end

    instr_fetch_queue_fifo #(
        .DEPTH (DEPTH),
        .T     (entry_t)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_s),
        .pop       (pop_s),
        .clear     (bus.redirect_valid),
        .push_data (push_data_s),
        .head      (head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s)
    );

    instr_fetch_queue_chk #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_chk (
        .clk         (clk),
        .reset       (reset),
        .resp_valid  (bus.imem_resp_valid),
        .push        (push_s),
        .pop         (pop_s),
        .full        (fifo_full_s),
        .count       (fifo_count_s),
        .outstanding (outstanding_r)
    );

    assign bus.imem_req_valid = req_valid_s;
    assign bus.imem_req_addr  = fetch_pc_r;
    assign bus.if_valid       = if_valid_s;
    assign bus.if_instr       = head_s.instr;
    assign bus.if_pc          = head_s.pc;

endmodule
